// File: rtl/serial_arith_pkg.sv
// Shared constants for the digit-serial arithmetic units:
// FSM state encodings and add/sub mode values.
package serial_arith_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_sub_digit_adder.sv
// Combinational DIGIT-bit adder with carry-in/out; also exports the carry
// into the digit MSB so the caller can derive signed overflow.
module digit_adder #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [DIGIT:0] full;

   assign full  = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
   assign sum   = full[DIGIT-1:0];
   assign cout  = full[DIGIT];
   // Carry into the MSB recovered from the MSB sum bit; works for DIGIT=1 too.
   assign c_msb = full[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial add/subtract unit: WIDTH-bit operands, DIGIT bits per cycle,
// LSB digit first, valid/ready handshakes, carry/borrow and overflow flags.
module serial_add_sub
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             add_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_sign,
   output logic             overflow
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   generate
      if ((DIGIT < 1) || (DIGIT > WIDTH) || (WIDTH % DIGIT != 0)) begin : g_bad_params
         $error("serial_add_sub: WIDTH must be a positive multiple of DIGIT");
      end
   endgenerate

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_sign_q, carry_sign_d;
   logic             overflow_q, overflow_d;

   logic [DIGIT-1:0] a_dig, b_dig, sum_dig;
   logic             cout, c_msb;

   assign a_dig = a_q[cnt_q*DIGIT +: DIGIT];
   assign b_dig = b_q[cnt_q*DIGIT +: DIGIT];

   digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
      .a     (a_dig),
      .b     (b_dig),
      .cin   (carry_q),
      .sum   (sum_dig),
      .cout  (cout),
      .c_msb (c_msb)
   );

   // Digits accumulate in acc_q; visible result/flags update only on entry to DONE.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      carry_d      = carry_q;
      mode_d       = mode_q;
      a_d          = a_q;
      b_d          = b_q;
      acc_d        = acc_q;
      result_d     = result_q;
      carry_sign_d = carry_sign_q;
      overflow_d   = overflow_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = (add_sub == OP_ADD) ? b : ~b;
               mode_d  = add_sub;
               carry_d = add_sub;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d[cnt_q*DIGIT +: DIGIT] = sum_dig;
            carry_d = cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cnt_d        = '0;
               result_d     = acc_d;
               carry_sign_d = cout ^ (mode_q == OP_SUB);
               overflow_d   = c_msb ^ cout;
               state_d      = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         carry_q      <= 1'b0;
         mode_q       <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         acc_q        <= '0;
         result_q     <= '0;
         carry_sign_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         carry_q      <= carry_d;
         mode_q       <= mode_d;
         a_q          <= a_d;
         b_q          <= b_d;
         acc_q        <= acc_d;
         result_q     <= result_d;
         carry_sign_q <= carry_sign_d;
         overflow_q   <= overflow_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign result     = result_q;
   assign carry_sign = carry_sign_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed-vector bench for serial_add_sub: main instance at DIGIT=4 plus
// DIGIT=1/8/16 instances for the parameter sweep.
module tb_serial_add_sub;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        add_sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] result;
   logic        carry_sign;
   logic        overflow;

   logic [2:0]  sw_in_valid = '0;
   logic [2:0]  sw_in_ready;
   logic [2:0]  sw_out_valid;
   logic [2:0]  sw_out_ready = '0;
   logic [15:0] sw_result [3];
   logic [2:0]  sw_cs;
   logic [2:0]  sw_ov;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .add_sub(add_sub), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .carry_sign(carry_sign), .overflow(overflow));

   serial_add_sub #(.WIDTH(16), .DIGIT(1)) dut_d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid[0]), .in_ready(sw_in_ready[0]),
      .a(a), .b(b), .add_sub(add_sub), .out_valid(sw_out_valid[0]), .out_ready(sw_out_ready[0]),
      .result(sw_result[0]), .carry_sign(sw_cs[0]), .overflow(sw_ov[0]));

   serial_add_sub #(.WIDTH(16), .DIGIT(8)) dut_d8 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid[1]), .in_ready(sw_in_ready[1]),
      .a(a), .b(b), .add_sub(add_sub), .out_valid(sw_out_valid[1]), .out_ready(sw_out_ready[1]),
      .result(sw_result[1]), .carry_sign(sw_cs[1]), .overflow(sw_ov[1]));

   serial_add_sub #(.WIDTH(16), .DIGIT(16)) dut_d16 (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid[2]), .in_ready(sw_in_ready[2]),
      .a(a), .b(b), .add_sub(add_sub), .out_valid(sw_out_valid[2]), .out_ready(sw_out_ready[2]),
      .result(sw_result[2]), .carry_sign(sw_cs[2]), .overflow(sw_ov[2]));

   // Stimulus only: present one op to the main instance, count edges to out_valid.
   task automatic start_main(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                             output int cyc, output bit timeout);
      @(posedge clk); #1;
      a = ta; b = tb; add_sub = ts; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = ~ta; b = ~tb; add_sub = ~ts;
      cyc = 0;
      timeout = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (out_valid) begin
            timeout = 1'b0;
            break;
         end
      end
   endtask

   task automatic release_main();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_vec++; if (result !== 16'h0000) begin n_err++; $display("FAIL reset_result: got %h want 0000", result); end
      n_vec++; if ({carry_sign, overflow} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {carry_sign, overflow}); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_hs: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
   endtask

   task automatic test_add();
      int cyc; bit to;
      start_main(16'hB3E7, 16'h6EDB, 1'b0, cyc, to);
      n_vec++; if (to) begin n_err++; $display("FAIL add_timeout: out_valid never rose within 40 cycles"); end
      n_vec++; if (cyc !== 4) begin n_err++; $display("FAIL add_latency: got %0d want 4", cyc); end
      n_vec++; if (result !== 16'h22C2) begin n_err++; $display("FAIL add_result: got %h want 22c2", result); end
      n_vec++; if (carry_sign !== 1'b1) begin n_err++; $display("FAIL add_carry: got %b want 1", carry_sign); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL add_ovf: got %b want 0", overflow); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL add_in_ready_done: got %b want 0", in_ready); end
      release_main();
      n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL add_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
      n_vec++; if (result !== 16'h22C2) begin n_err++; $display("FAIL add_result_held: got %h want 22c2", result); end
   endtask

   task automatic test_sub_overflow();
      int cyc; bit to;
      start_main(16'h9F98, 16'h7E63, 1'b1, cyc, to);
      n_vec++; if (to) begin n_err++; $display("FAIL sub_timeout: out_valid never rose within 40 cycles"); end
      n_vec++; if (result !== 16'h2135) begin n_err++; $display("FAIL sub_result: got %h want 2135", result); end
      n_vec++; if (carry_sign !== 1'b0) begin n_err++; $display("FAIL sub_borrow: got %b want 0", carry_sign); end
      n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL sub_ovf: got %b want 1", overflow); end
      release_main();
   endtask

   task automatic test_borrow();
      int cyc; bit to;
      start_main(16'h0001, 16'h0002, 1'b1, cyc, to);
      n_vec++; if (to) begin n_err++; $display("FAIL borrow_timeout: out_valid never rose within 40 cycles"); end
      n_vec++; if (result !== 16'hFFFF) begin n_err++; $display("FAIL borrow_result: got %h want ffff", result); end
      n_vec++; if (carry_sign !== 1'b1) begin n_err++; $display("FAIL borrow_flag: got %b want 1", carry_sign); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL borrow_ovf: got %b want 0", overflow); end
      release_main();
      start_main(16'h7FFF, 16'h0001, 1'b0, cyc, to);
      n_vec++; if (to) begin n_err++; $display("FAIL addovf_timeout: out_valid never rose within 40 cycles"); end
      n_vec++; if (result !== 16'h8000) begin n_err++; $display("FAIL addovf_result: got %h want 8000", result); end
      n_vec++; if (carry_sign !== 1'b0) begin n_err++; $display("FAIL addovf_carry: got %b want 0", carry_sign); end
      n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL addovf_ovf: got %b want 1", overflow); end
      release_main();
   endtask

   task automatic test_back_pressure();
      int cyc; bit to;
      start_main(16'h1234, 16'h1111, 1'b0, cyc, to);
      n_vec++; if (to) begin n_err++; $display("FAIL bp_timeout: out_valid never rose within 40 cycles"); end
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin a = 16'hFFFF; b = 16'hFFFF; add_sub = 1'b0; in_valid = 1'b1; end
         else in_valid = 1'b0;
         @(posedge clk); #1;
         n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
         n_vec++; if (result !== 16'h2345) begin n_err++; $display("FAIL bp_result[%0d]: got %h want 2345", i, result); end
         n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      end
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
      @(posedge clk); #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_no_accept: got in_ready=%b want 1", in_ready); end
      n_vec++; if (result !== 16'h2345) begin n_err++; $display("FAIL bp_result_after: got %h want 2345", result); end
   endtask

   task automatic test_reset_mid_op();
      int cyc; bit to;
      @(posedge clk); #1;
      a = 16'h1234; b = 16'h4321; add_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_vec++; if (result !== 16'h0000) begin n_err++; $display("FAIL rst_mid_result: got %h want 0000", result); end
      n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_hs: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
      n_vec++; if ({carry_sign, overflow} !== 2'b00) begin n_err++; $display("FAIL rst_mid_flags: got %b want 00", {carry_sign, overflow}); end
      #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
      start_main(16'hFFFF, 16'h0C02, 1'b1, cyc, to);
      n_vec++; if (to) begin n_err++; $display("FAIL rst_next_timeout: out_valid never rose within 40 cycles"); end
      n_vec++; if (result !== 16'hF3FD) begin n_err++; $display("FAIL rst_next_result: got %h want f3fd", result); end
      n_vec++; if ({carry_sign, overflow} !== 2'b00) begin n_err++; $display("FAIL rst_next_flags: got %b want 00", {carry_sign, overflow}); end
      release_main();
   endtask

   task automatic test_param_sweep();
      int lat_exp [3];
      lat_exp[0] = 16; lat_exp[1] = 2; lat_exp[2] = 1;
      for (int k = 0; k < 3; k++) begin
         int cyc;
         bit to;
         @(posedge clk); #1;
         a = 16'hB3E7; b = 16'h6EDB; add_sub = 1'b0; sw_in_valid[k] = 1'b1;
         @(posedge clk); #1;
         sw_in_valid[k] = 1'b0;
         a = '0; b = '0; add_sub = 1'b1;
         cyc = 0; to = 1'b1;
         for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (sw_out_valid[k]) begin to = 1'b0; break; end
         end
         n_vec++; if (to) begin n_err++; $display("FAIL sweep%0d_timeout: out_valid never rose within 40 cycles", k); end
         n_vec++; if (cyc !== lat_exp[k]) begin n_err++; $display("FAIL sweep%0d_latency: got %0d want %0d", k, cyc, lat_exp[k]); end
         n_vec++; if (sw_result[k] !== 16'h22C2) begin n_err++; $display("FAIL sweep%0d_result: got %h want 22c2", k, sw_result[k]); end
         n_vec++; if ({sw_cs[k], sw_ov[k]} !== 2'b10) begin n_err++; $display("FAIL sweep%0d_flags: got %b want 10", k, {sw_cs[k], sw_ov[k]}); end
         sw_out_ready[k] = 1'b1;
         @(posedge clk); #1;
         sw_out_ready[k] = 1'b0;
         n_vec++; if (sw_in_ready[k] !== 1'b1) begin n_err++; $display("FAIL sweep%0d_release: got in_ready=%b want 1", k, sw_in_ready[k]); end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_overflow();
      test_borrow();
      test_back_pressure();
      test_reset_mid_op();
      test_param_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
